// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 16-iteration shift-add multiply / restoring divide sequencer driving a shared 16-bit ALU
module alu_muldiv_seq #(
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_SUB = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_s,
  input  logic [15:0] alu_r,
  input  logic        alu_lt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] acc, mcand, mplier, rem, dq, divisor;
  logic [15:0] shifted, acc_n, rem_n, dq_n;
  logic [3:0] count;
  logic op_q, accept, div0, last, take;
  always_comb begin
    accept = start && state != RUN;
    div0 = op && b == 16'd0;
    last = count == 4'd15;
    shifted = {rem[14:0], dq[15]};
    // rem[15] set means the true 17-bit partial remainder exceeds any divisor
    take = rem[15] | ~alu_lt;
    acc_n = mplier[0] ? alu_r : acc;
    rem_n = take ? alu_r : shifted;
    dq_n = {dq[14:0], take};
    state_n = state == RUN ? (last ? DONE : RUN) : accept ? (div0 ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
    alu_a = busy ? (op_q ? shifted : acc) : 16'd0;
    alu_b = busy ? (op_q ? divisor : mcand) : 16'd0;
    alu_s = busy && op_q ? ALU_SUB : ALU_ADD;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      rem <= '0;
      dq <= '0;
      divisor <= '0;
      count <= '0;
      op_q <= 1'b0;
      err <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else if (accept) begin
      acc <= '0;
      mcand <= a;
      mplier <= b;
      rem <= '0;
      dq <= a;
      divisor <= b;
      count <= '0;
      op_q <= op;
      err <= div0;
      if (div0) begin
        result_lo <= 16'hFFFF;
        result_hi <= a;
      end
    end else if (busy) begin
      count <= count + 4'd1;
      if (op_q) begin
        rem <= rem_n;
        dq <= dq_n;
      end else begin
        acc <= acc_n;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (last) begin
        result_lo <= op_q ? dq_n : acc_n;
        result_hi <= op_q ? rem_n : 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed table, hand-written corner sequences and random ops against an arithmetic model
module tb_alu_muldiv_seq;
  logic clk = 0, reset = 1, start = 0, op = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done, err;
  logic [15:0] result_lo, result_hi, alu_a, alu_b, alu_r;
  logic [2:0] alu_s;
  logic alu_lt;
  int tests = 0, fails = 0;

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result_lo(result_lo), .result_hi(result_hi),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_r(alu_r), .alu_lt(alu_lt)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_r = alu_s == 3'd1 ? alu_a - alu_b : alu_a + alu_b;
    alu_lt = alu_a < alu_b;
  end

  always @(negedge clk)
    if (busy && done) begin
      fails++;
      $display("FAIL busy_and_done: both high at %0t", $time);
    end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_done(input int l0, output int lat, output int busy_n);
    lat = l0;
    busy_n = 0;
    while (!done && lat < 40) begin
      busy_n += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drives start for one edge from an off-edge point, scrambles operands afterwards, waits for done.
  task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y, output int lat, output int busy_n);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; op = $urandom; a = $urandom; b = $urandom;
    wait_done(1, lat, busy_n);
  endtask

  typedef struct {
    logic o;
    logic [15:0] x, y, lo, hi;
    logic e;
    int lat;
  } vec_t;

  vec_t vecs[7];
  int lat, bn, nd;
  logic [15:0] elo, ehi;
  logic ee, ro;
  logic [15:0] rx, ry;

  initial begin
    vecs[0] = '{1'b0, 16'd7, 16'd6, 16'h002A, 16'h0, 1'b0, 17};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 17};
    vecs[2] = '{1'b0, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0, 17};
    vecs[3] = '{1'b1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0, 17};
    vecs[5] = '{1'b1, 16'h00AB, 16'h0, 16'hFFFF, 16'h00AB, 1'b1, 1};
    vecs[6] = '{1'b0, 16'd3, 16'd5, 16'd15, 16'h0, 1'b0, 17};

    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_s", alu_s, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].o, vecs[i].x, vecs[i].y, lat, bn);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bn, vecs[i].lat == 1 ? 0 : 16);
      check($sformatf("v%0d_lo", i), result_lo, vecs[i].lo);
      check($sformatf("v%0d_hi", i), result_hi, vecs[i].hi);
      check($sformatf("v%0d_err", i), err, vecs[i].e);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
    end

    // divide by zero: err and results hold through idle cycles
    @(posedge clk); #1;
    do_op(1'b1, 16'h00AB, 16'h0, lat, bn);
    repeat (3) @(posedge clk); #1;
    check("dz_hold_err", err, 1);
    check("dz_hold_lo", result_lo, 16'hFFFF);
    check("dz_hold_done", done, 0);

    // start during RUN is ignored; then a back-to-back start in the DONE cycle
    start = 1; op = 1; a = 100; b = 7;
    @(posedge clk); #1;
    start = 0;
    check("div_alu_s", alu_s, 1);
    check("div_alu_b", alu_b, 7);
    repeat (4) @(posedge clk); #1;
    start = 1; op = 0; a = 2; b = 2;
    @(posedge clk); #1;
    start = 0;
    wait_done(6, lat, bn);
    check("ign_lat", lat, 17);
    check("ign_lo", result_lo, 14);
    check("ign_hi", result_hi, 2);
    do_op(1'b0, 16'h0102, 16'h0003, lat, bn);
    check("b2b_lat", lat, 17);
    check("b2b_lo", result_lo, 16'h0306);

    // reset at RUN cycle 8
    start = 1; op = 1; a = 100; b = 7;
    @(posedge clk); #1;
    start = 0;
    repeat (7) @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    reset = 1; start = 1; op = 0; a = 5; b = 5;
    @(posedge clk); #1;
    reset = 0; start = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lo", result_lo, 0);
    check("mid_rst_hi", result_hi, 0);
    nd = 0;
    repeat (20) begin
      nd += int'(done) + int'(busy);
      @(posedge clk); #1;
    end
    check("mid_rst_no_activity", nd, 0);
    do_op(1'b0, 16'd9, 16'd9, lat, bn);
    check("post_rst_lo", result_lo, 81);
    check("post_rst_lat", lat, 17);

    for (int i = 0; i < 60; i++) begin
      ro = $urandom;
      rx = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      ry = ($urandom_range(0, 5) == 0) ? 16'h0 : ($urandom_range(0, 3) == 0 ? 16'($urandom_range(1, 15)) : 16'($urandom));
      if (ro && ry == 0) begin
        elo = 16'hFFFF; ehi = rx; ee = 1;
      end else if (ro) begin
        elo = rx / ry; ehi = rx % ry; ee = 0;
      end else begin
        elo = 16'((32'(rx) * 32'(ry)) & 32'hFFFF); ehi = 0; ee = 0;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_op(ro, rx, ry, lat, bn);
      check($sformatf("rnd%0d_lo op=%0d %0h %0h", i, ro, rx, ry), result_lo, elo);
      check($sformatf("rnd%0d_hi", i), result_hi, ehi);
      check($sformatf("rnd%0d_err", i), err, ee);
      check($sformatf("rnd%0d_lat", i), lat, ee ? 1 : 17);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
